// File: rtl/serial_word_alu.sv
// Byte-serial WIDTH-bit add/sub/accumulate engine: operands in and result out one byte per beat, LSB first.
// Optional ALU_SATURATE_EN clamps overflowing ADD/ACC results to all-ones and underflowing SUB results to zero.
module serial_word_alu #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  input  logic [1:0] mode,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       carry
);

  localparam int NBYTES = WIDTH / 8;
  localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(NBYTES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_SEND = 2'd3;

  localparam logic [1:0] M_ADD = 2'b00;
  localparam logic [1:0] M_SUB = 2'b01;
  localparam logic [1:0] M_ACC = 2'b10;

  logic [1:0]       state_q, state_d;
  logic [1:0]       mode_q, mode_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [WIDTH:0]   calc;
  logic [7:0]       res_byte;

  // The MSB of calc is carry for ADD/ACC and borrow (A<B) for SUB.
  always_comb begin
    calc = '0;
    unique case (mode_q)
      M_ADD:   calc = {1'b0, a_q} + {1'b0, b_q};
      M_SUB:   calc = {1'b0, a_q} - {1'b0, b_q};
      M_ACC:   calc = {1'b0, acc_q} + {1'b0, a_q};
      default: calc = '0;
    endcase
`ifdef ALU_SATURATE_EN
    if (calc[WIDTH]) begin
      calc[WIDTH-1:0] = (mode_q == M_SUB) ? '0 : '1;
    end
`endif
  end

  always_comb begin
    res_byte = '0;
    for (int unsigned i = 0; i < NBYTES; i++) begin
      if (idx_q == CW'(i)) res_byte = res_q[8*i +: 8];
    end
  end

  // One counter serves both the load and send phases since they never overlap.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    res_d   = res_q;
    carry_d = carry_q;
    unique case (state_q)
      S_IDLE, S_LOAD: begin
        if (in_valid) begin
          if (state_q == S_IDLE) mode_d = mode;
          for (int unsigned i = 0; i < NBYTES; i++) begin
            if (idx_q == CW'(i)) begin
              a_d[8*i +: 8] = op_a;
              b_d[8*i +: 8] = op_b;
            end
          end
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_CALC;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_CALC: begin
        res_d   = calc[WIDTH-1:0];
        carry_d = calc[WIDTH];
        acc_d   = calc[WIDTH-1:0];
        idx_d   = '0;
        state_d = S_SEND;
      end
      default: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      carry_q <= carry_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign out_valid = (state_q == S_SEND);
  assign out_data  = out_valid ? res_byte : '0;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign carry     = carry_q;

endmodule

// File: tb/tb_serial_word_alu.sv
// Self-checking bench for serial_word_alu at WIDTH=16: directed vectors, backpressure and reset
// sequences, then randomized operations against an arithmetic reference model.
module tb_serial_word_alu;

  localparam int W  = 16;
  localparam int NB = W / 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic [1:0] mode = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       carry;

  int n_checks = 0;
  int n_fail   = 0;
  longint unsigned model_acc = 0;

  typedef struct {
    logic [1:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic         c;
  } vec_t;

  vec_t vecs[6];

  serial_word_alu #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op_a     (op_a),
    .op_b     (op_b),
    .mode     (mode),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .carry    (carry)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full operand values.
  function automatic void ref_op(input logic [1:0] m, input longint unsigned a, input longint unsigned b,
                                 input longint unsigned acc, output longint unsigned r, output bit c);
    longint unsigned full;
    longint unsigned s;
    full = 64'd1 << W;
    r = 0;
    c = 1'b0;
    case (m)
      2'b00: begin
        s = a + b;
        c = (s >= full);
        r = s % full;
`ifdef ALU_SATURATE_EN
        if (c) r = full - 1;
`endif
      end
      2'b01: begin
        c = (a < b);
        r = (a + full - b) % full;
`ifdef ALU_SATURATE_EN
        if (c) r = 0;
`endif
      end
      2'b10: begin
        s = acc + a;
        c = (s >= full);
        r = s % full;
`ifdef ALU_SATURATE_EN
        if (c) r = full - 1;
`endif
      end
      default: begin
        r = 0;
        c = 1'b0;
      end
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that took the last byte.
  task automatic send_ops(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b, input bit gaps);
    for (int i = 0; i < NB; i++) begin
      int t;
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      op_a = a[8*i +: 8];
      op_b = b[8*i +: 8];
      mode = (i == 0) ? m : 2'($urandom);
      t = 0;
      while (!in_ready && t < 20) begin
        @(posedge clk);
        #1;
        t++;
      end
      check("in_ready_wait", 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
  endtask

  task automatic recv(input logic [W-1:0] exp_r, input bit exp_c, input int stall0, input bit rand_rdy);
    for (int j = 0; j < NB; j++) begin
      int  t;
      int  stalls;
      bit  done;
      t = 0;
      stalls = 0;
      done = 1'b0;
      while (!done) begin
        if (t > 40) begin
          check("out_beat_timeout", 64'd0, 64'd1);
          out_ready = 1'b0;
          return;
        end
        if (out_valid) begin
          check("out_data", 64'(out_data), 64'(exp_r[8*j +: 8]));
          check("out_last", 64'(out_last), 64'(j == NB - 1));
          if (j == NB - 1) check("carry", 64'(carry), 64'(exp_c));
          check("in_ready_busy", 64'(in_ready), 64'd0);
          if (j == 0 && stalls < stall0) begin
            out_ready = 1'b0;
            stalls++;
          end else begin
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
          end
          done = out_ready;
        end
        @(posedge clk);
        #1;
        t++;
      end
      out_ready = 1'b0;
    end
    check("out_valid_after_last", 64'(out_valid), 64'd0);
    check("in_ready_after_last", 64'(in_ready), 64'd1);
  endtask

  task automatic do_op(input logic [1:0] m, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] exp_r, input bit exp_c,
                       input bit gaps, input int stall0, input bit rand_rdy);
    send_ops(m, a, b, gaps);
    check("calc_cycle_valid", 64'(out_valid), 64'd0);
    check("calc_cycle_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("first_out_latency", 64'(out_valid), 64'd1);
    recv(exp_r, exp_c, stall0, rand_rdy);
  endtask

  initial begin
    longint unsigned r;
    bit c;
    logic [1:0]   m;
    logic [W-1:0] a;
    logic [W-1:0] b;

    vecs[0] = '{m: 2'b00, a: 16'h00FF, b: 16'h0001, r: 16'h0100, c: 1'b0};
`ifdef ALU_SATURATE_EN
    vecs[1] = '{m: 2'b00, a: 16'hFFFF, b: 16'h0002, r: 16'hFFFF, c: 1'b1};
    vecs[2] = '{m: 2'b01, a: 16'h0003, b: 16'h0005, r: 16'h0000, c: 1'b1};
`else
    vecs[1] = '{m: 2'b00, a: 16'hFFFF, b: 16'h0002, r: 16'h0001, c: 1'b1};
    vecs[2] = '{m: 2'b01, a: 16'h0003, b: 16'h0005, r: 16'hFFFE, c: 1'b1};
`endif
    vecs[3] = '{m: 2'b11, a: 16'hBEEF, b: 16'h0000, r: 16'h0000, c: 1'b0};
    vecs[4] = '{m: 2'b10, a: 16'h1234, b: 16'h0000, r: 16'h1234, c: 1'b0};
    vecs[5] = '{m: 2'b10, a: 16'h0001, b: 16'h0000, r: 16'h1235, c: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_last", 64'(out_last), 64'd0);
    check("rst_carry", 64'(carry), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      b = vecs[i].b;
      if (vecs[i].m[1]) b = 16'($urandom);
      do_op(vecs[i].m, vecs[i].a, b, vecs[i].r, vecs[i].c, 1'b0, 0, 1'b0);
      model_acc = vecs[i].r;
    end

    // Backpressure: three stalled cycles on byte 0; values are rechecked every stalled cycle.
    do_op(2'b00, 16'h1357, 16'h2468, 16'h37BF, 1'b0, 1'b0, 3, 1'b0);
    model_acc = 16'h37BF;

    for (int i = 0; i < 40; i++) begin
      m = 2'($urandom);
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 5 == 0) a = 16'hFFFF;
      ref_op(m, a, b, model_acc, r, c);
      do_op(m, a, b, r[W-1:0], c, 1'b1, 0, 1'b1);
      model_acc = r;
    end

    // Reset in SEND abandons the result and clears the accumulator.
    send_ops(2'b00, 16'h0102, 16'h0304, 1'b0);
    @(posedge clk);
    #1;
    check("pre_reset_send", 64'(out_valid), 64'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("reset_mid_out_valid", 64'(out_valid), 64'd0);
    check("reset_mid_in_ready", 64'(in_ready), 64'd1);
    check("reset_mid_out_data", 64'(out_data), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_acc = 0;
    @(posedge clk);
    #1;
    do_op(2'b10, 16'h0005, 16'($urandom), 16'h0005, 1'b0, 1'b0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
